// File: rtl/if_axi_fetch.sv
// Instruction-fetch stage: owns the PC, issues one single-beat AXI4 read per
// instruction and holds the result on the IF/ID interface until decode consumes it.
module if_axi_fetch #(
    parameter logic [63:0] PC_INIT = 64'h0000_0000_8000_0000,
    parameter logic [3:0]  AXI_ID  = 4'd0
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        id_stall,
    input  logic        data_read_stall,
    input  logic        flush,
    input  logic [63:0] flush_pc,
    input  logic        excep_flush,
    input  logic [63:0] excep_pc,
    input  logic        bp_jump_ena,
    input  logic [63:0] bp_jump_pc,
    output logic [63:0] if_pc,
    output logic [63:0] if_pc_plus_4,
    output logic [31:0] if_inst,
    output logic        if_jump_ena,
    output logic [63:0] if_jump_pc,
    output logic        handshake_done,
    output logic        if_fetch_fault,
    output logic        arvalid,
    input  logic        arready,
    output logic [63:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] redir_pc_q, redir_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic        jena_q, jena_d;
    logic [63:0] jpc_q, jpc_d;

    logic        redir, beat, stalled;
    logic [63:0] redir_tgt;

    assign redir     = excep_flush | flush;
    assign redir_tgt = excep_flush ? excep_pc : flush_pc;
    assign stalled   = id_stall | data_read_stall;
    assign beat      = rvalid && (rid == AXI_ID) && rlast;

    assign if_pc          = pc_q;
    assign if_pc_plus_4   = pc_q + 64'd4;
    assign if_inst        = inst_q;
    assign if_jump_ena    = jena_q;
    assign if_jump_pc     = jpc_q;
    assign if_fetch_fault = fault_q;
    assign araddr         = pc_q;
    assign arid           = AXI_ID;
    assign arlen          = 8'd0;
    assign arsize         = 3'b010;
    assign arburst        = 2'b01;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        redir_pc_d     = redir_pc_q;
        discard_d      = discard_q;
        inst_d         = inst_q;
        fault_d        = fault_q;
        jena_d         = jena_q;
        jpc_d          = jpc_q;
        arvalid        = 1'b0;
        rready         = 1'b0;
        handshake_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redir) pc_d = redir_tgt;
                state_d = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                // An issued address cannot be withdrawn; remember where to go instead.
                if (redir) begin
                    discard_d  = 1'b1;
                    redir_pc_d = redir_tgt;
                end
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (beat) begin
                    if (discard_q || redir) begin
                        discard_d = 1'b0;
                        pc_d      = redir ? redir_tgt : redir_pc_q;
                        state_d   = S_AR;
                    end else begin
                        fault_d = (rresp != 2'b00);
                        inst_d  = (rresp != 2'b00) ? 32'h0 :
                                  (pc_q[2] ? rdata[63:32] : rdata[31:0]);
                        jena_d  = bp_jump_ena;
                        jpc_d   = bp_jump_pc;
                        state_d = S_HOLD;
                    end
                end else if (redir) begin
                    discard_d  = 1'b1;
                    redir_pc_d = redir_tgt;
                end
            end
            S_HOLD: begin
                handshake_done = 1'b1;
                // A flush overrides any stall; otherwise advance only when decode is free.
                if (redir) begin
                    pc_d    = redir_tgt;
                    state_d = S_AR;
                end else if (!stalled) begin
                    pc_d    = jena_q ? jpc_q : pc_q + 64'd4;
                    state_d = S_AR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_INIT;
            redir_pc_q <= 64'h0;
            discard_q  <= 1'b0;
            inst_q     <= 32'h0;
            fault_q    <= 1'b0;
            jena_q     <= 1'b0;
            jpc_q      <= 64'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            discard_q  <= discard_d;
            inst_q     <= inst_d;
            fault_q    <= fault_d;
            jena_q     <= jena_d;
            jpc_q      <= jpc_d;
        end
    end
endmodule

// File: tb/tb_if_axi_fetch.sv
// Bench for if_axi_fetch: AXI slave model over a word memory, directed steps,
// then a randomized phase checked against an architectural PC-sequence model.
module tb_if_axi_fetch;
    localparam logic [63:0] PC_INIT = 64'h0000_0000_8000_0000;
    localparam logic [3:0]  AXI_ID  = 4'd0;

    logic        clk, rst;
    logic        id_stall, data_read_stall, flush, excep_flush;
    logic [63:0] flush_pc, excep_pc;
    logic        bp_jump_ena;
    logic [63:0] bp_jump_pc;
    logic [63:0] if_pc, if_pc_plus_4, if_jump_pc, araddr;
    logic [31:0] if_inst;
    logic        if_jump_ena, handshake_done, if_fetch_fault, arvalid, rready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arready, rvalid, rlast;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;

    int total = 0;
    int bad   = 0;

    // slave / environment knobs
    bit          ar_rand, lat_rand, stray_en, bp_rand, flt_rand;
    int          lat_fix;
    logic [63:0] bp_force_pc, bp_force_tgt, fault_pc;

    // reference model state
    logic [63:0] exp_pc, exp_jpc;
    logic        exp_jena;
    logic [63:0] snap_pc;
    logic [31:0] snap_inst;
    bit          presented;
    int          npres;

    if_axi_fetch #(.PC_INIT(PC_INIT), .AXI_ID(AXI_ID)) dut (
        .cpu_clk_50M(clk), .cpu_rst(rst),
        .id_stall(id_stall), .data_read_stall(data_read_stall),
        .flush(flush), .flush_pc(flush_pc),
        .excep_flush(excep_flush), .excep_pc(excep_pc),
        .bp_jump_ena(bp_jump_ena), .bp_jump_pc(bp_jump_pc),
        .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4), .if_inst(if_inst),
        .if_jump_ena(if_jump_ena), .if_jump_pc(if_jump_pc),
        .handshake_done(handshake_done), .if_fetch_fault(if_fetch_fault),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0093;
        if (a == 64'h8000_0004) return 32'h0000_0013;
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic bp_en(input logic [63:0] a);
        return (a == bp_force_pc) || (bp_rand && a[6:4] == 3'd5);
    endfunction

    function automatic logic [63:0] bp_tgt(input logic [63:0] a);
        return (a == bp_force_pc) ? bp_force_tgt : a + 64'h24;
    endfunction

    function automatic logic fault_at(input logic [63:0] a);
        return (a == fault_pc) || (flt_rand && a[7:2] == 6'h2A);
    endfunction

    // Combinational predictor lookup on the presented PC.
    assign bp_jump_ena = (if_pc == bp_force_pc) || (bp_rand && if_pc[6:4] == 3'd5);
    assign bp_jump_pc  = (if_pc == bp_force_pc) ? bp_force_tgt : if_pc + 64'h24;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // AXI read slave: inputs change on the falling edge.
    initial begin
        logic        pend;
        logic [63:0] paddr;
        int          dly;
        pend = 1'b0; paddr = '0; dly = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = AXI_ID;
        forever begin
            @(negedge clk);
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = AXI_ID; rdata = '0; rresp = 2'b00;
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                chk("one_outstanding_ar", 64'(arvalid), 64'd0);
                if (dly == 0) begin
                    rvalid = 1'b1; rlast = 1'b1; rid = AXI_ID;
                    rdata  = {word_at({paddr[63:3], 3'b100}), word_at({paddr[63:3], 3'b000})};
                    rresp  = !fault_at(paddr) ? 2'b00 :
                             (flt_rand && $urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
                    if (rready) pend = 1'b0;
                end else begin
                    dly--;
                    if (stray_en && $urandom_range(0, 2) == 0) begin
                        rvalid = 1'b1;
                        rdata  = {32'($urandom), 32'($urandom)};
                        if ($urandom_range(0, 1) == 1) begin rid = 4'hA; rlast = 1'b1; end
                        else begin rid = AXI_ID; rlast = 1'b0; end
                    end
                end
            end else if (arvalid && (!ar_rand || $urandom_range(0, 1) == 1)) begin
                arready = 1'b1;
                pend    = 1'b1;
                paddr   = araddr;
                dly     = lat_rand ? $urandom_range(0, 3) : lat_fix;
            end
        end
    end

    // One clock: update the PC model from pre-edge controls, then check outputs.
    task automatic tick();
        logic        hd0, stl0, fl0;
        logic [63:0] tgt0;
        logic        efault;
        hd0  = handshake_done;
        stl0 = id_stall | data_read_stall;
        fl0  = flush | excep_flush;
        tgt0 = excep_flush ? excep_pc : flush_pc;
        @(posedge clk);
        #1;
        if (fl0) exp_pc = tgt0;
        else if (hd0 && !stl0) exp_pc = exp_jena ? exp_jpc : exp_pc + 64'd4;
        presented = 1'b0;
        if (handshake_done && !hd0) begin
            presented = 1'b1;
            npres++;
            efault   = fault_at(exp_pc);
            exp_jena = bp_en(exp_pc);
            exp_jpc  = bp_tgt(exp_pc);
            chk("pres_pc", if_pc, exp_pc);
            chk("pres_pc4", if_pc_plus_4, exp_pc + 64'd4);
            chk("pres_inst", 64'(if_inst), efault ? 64'd0 : 64'(word_at(exp_pc)));
            chk("pres_fault", 64'(if_fetch_fault), 64'(efault));
            chk("pres_jena", 64'(if_jump_ena), 64'(exp_jena));
            if (exp_jena) chk("pres_jpc", if_jump_pc, exp_jpc);
            snap_pc   = if_pc;
            snap_inst = if_inst;
        end else if (handshake_done && hd0) begin
            chk("hold_pc", if_pc, snap_pc);
            chk("hold_inst", 64'(if_inst), 64'(snap_inst));
        end
    endtask

    task automatic wait_present(input int budget);
        presented = 1'b0;
        for (int i = 0; i < budget && !presented; i++) tick();
        chk("present_in_budget", 64'(presented), 64'd1);
    endtask

    task automatic pulse_flush(input logic [63:0] tgt);
        flush = 1'b1; flush_pc = tgt;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        int npres_r;
        rst = 1'b1; id_stall = 0; data_read_stall = 0; flush = 0; excep_flush = 0;
        flush_pc = '0; excep_pc = '0;
        ar_rand = 0; lat_rand = 0; stray_en = 0; bp_rand = 0; flt_rand = 0; lat_fix = 0;
        bp_force_pc = 64'h1; bp_force_tgt = '0; fault_pc = 64'h1;
        exp_pc = PC_INIT; exp_jena = 0; exp_jpc = '0; snap_pc = '0; snap_inst = '0;
        presented = 0; npres = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_pc", if_pc, PC_INIT);
        chk("rst_pc4", if_pc_plus_4, PC_INIT + 64'd4);
        chk("rst_hd", 64'(handshake_done), 0);
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_rready", 64'(rready), 0);
        chk("rst_inst", 64'(if_inst), 0);
        chk("ar_consts", {44'd0, arid, arlen, arsize, arburst, 3'd0}, {44'd0, 4'd0, 8'd0, 3'b010, 2'b01, 3'd0});
        rst = 1'b0;

        // zero-wait timing: AR, beat, present; then the next sequential fetch
        tick(); chk("t0_arvalid", 64'(arvalid), 1); chk("t0_araddr", araddr, 64'h8000_0000);
        tick(); chk("t1_rready", 64'(rready), 1); chk("t1_hd", 64'(handshake_done), 0);
        tick(); chk("t2_hd", 64'(handshake_done), 1); chk("t2_inst", 64'(if_inst), 64'h93);
        tick(); chk("t3_araddr", araddr, 64'h8000_0004); chk("t3_arvalid", 64'(arvalid), 1);
        tick(); tick();
        chk("t5_hd", 64'(handshake_done), 1); chk("t5_inst", 64'(if_inst), 64'h13);

        // decode stall for 4 cycles while presenting
        id_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hd", 64'(handshake_done), 1);
            chk("stall_no_ar", 64'(arvalid), 0);
        end
        id_stall = 1'b0;
        tick();
        chk("unstall_hd", 64'(handshake_done), 0);
        chk("unstall_araddr", araddr, 64'h8000_0008);

        // flush while waiting for a slow R beat
        lat_fix = 5;
        for (int i = 0; i < 20 && !rready; i++) tick();
        chk("reach_R", 64'(rready), 1);
        pulse_flush(64'h8000_0100);
        for (int i = 0; i < 20 && !arvalid; i++) begin
            chk("discard_no_hd", 64'(handshake_done), 0);
            tick();
        end
        chk("redir_araddr", araddr, 64'h8000_0100);
        lat_fix = 0;
        wait_present(30);

        // exception flush beats branch flush and stall in HOLD
        id_stall = 1'b1; flush = 1'b1; excep_flush = 1'b1;
        excep_pc = 64'h8000_0200; flush_pc = 64'h8000_0300;
        tick();
        flush = 1'b0; excep_flush = 1'b0; id_stall = 1'b0;
        chk("exc_hd_fall", 64'(handshake_done), 0);
        chk("exc_arvalid", 64'(arvalid), 1);
        chk("exc_araddr", araddr, 64'h8000_0200);
        wait_present(30);

        // predicted jump, then a faulting fetch at the jump target
        bp_force_pc = 64'h8000_1000; bp_force_tgt = 64'h8000_0040; fault_pc = 64'h8000_0040;
        pulse_flush(64'h8000_1000);
        wait_present(30);
        chk("bp_jena", 64'(if_jump_ena), 1);
        tick(); chk("bp_araddr", araddr, 64'h8000_0040);
        wait_present(30);
        chk("flt_fault", 64'(if_fetch_fault), 1);
        chk("flt_inst", 64'(if_inst), 0);
        chk("flt_hd", 64'(handshake_done), 1);
        tick(); chk("flt_next", araddr, 64'h8000_0044);
        wait_present(30);

        // PC wrap at the top of the address space
        pulse_flush(64'hFFFF_FFFF_FFFF_FFFC);
        wait_present(30);
        chk("wrap_pc4", if_pc_plus_4, 64'h0);
        tick(); chk("wrap_araddr", araddr, 64'h0);
        wait_present(30);

        // randomized traffic
        ar_rand = 1; lat_rand = 1; stray_en = 1; bp_rand = 1; flt_rand = 1;
        bp_force_pc = 64'h1; fault_pc = 64'h1;
        npres_r = npres;
        for (int i = 0; i < 3000; i++) begin
            id_stall        = ($urandom_range(0, 3) == 0);
            data_read_stall = ($urandom_range(0, 7) == 0);
            flush           = ($urandom_range(0, 29) == 0);
            excep_flush     = ($urandom_range(0, 49) == 0);
            flush_pc        = 64'h8000_0000 + {50'd0, 12'($urandom_range(0, 1023)), 2'b00};
            excep_pc        = 64'h8000_4000 + {50'd0, 12'($urandom_range(0, 1023)), 2'b00};
            tick();
        end
        id_stall = 0; data_read_stall = 0; flush = 0; excep_flush = 0;
        chk("rand_progress", 64'(npres - npres_r > 50), 1);

        // asynchronous reset in the middle of a transaction
        ar_rand = 0; lat_rand = 0; stray_en = 0; bp_rand = 0; flt_rand = 0; lat_fix = 5;
        for (int i = 0; i < 40 && !rready; i++) tick();
        rst = 1'b1;
        #1;
        chk("arst_rready", 64'(rready), 0);
        chk("arst_arvalid", 64'(arvalid), 0);
        chk("arst_pc", if_pc, PC_INIT);
        chk("arst_hd", 64'(handshake_done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; lat_fix = 0;
        exp_pc = PC_INIT; exp_jena = 0;
        wait_present(30);
        chk("arst_inst", 64'(if_inst), 64'h93);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
